// File: rtl/acc_pkg.sv
// Shared types and arithmetic helpers for the bias-plus-sum frame accumulator.
// Helpers work on 64-bit operands; callers slice the result back to ACC_W.
package acc_pkg;

  localparam int IN_W_D   = 20;
  localparam int BIAS_W_D = 8;
  localparam int ACC_W_D  = 22;

  typedef enum logic [0:0] {IDLE, ACCUM} acc_state_t;

  typedef struct packed {
    logic [63:0] sum;
    logic        ovf;
  } add_res_t;

  // Replicate bit msb into every higher bit.
  function automatic logic [63:0] sext_acc(input logic [63:0] x, input logic [5:0] msb);
    logic [63:0] r;
    r = x;
    for (int i = 0; i < 64; i++) begin
      if (i > int'(msb)) r[i] = x[msb];
    end
    return r;
  endfunction

  // Sum plus signed overflow of an add that is (msb+1) bits wide.
  function automatic add_res_t add_ovf(input logic [63:0] a, input logic [63:0] b,
                                       input logic [5:0] msb);
    add_res_t    r;
    logic [63:0] s;
    s     = a + b;
    r.sum = s;
    r.ovf = (a[msb] == b[msb]) && (s[msb] != a[msb]);
    return r;
  endfunction

endpackage

// File: rtl/acc_frame_ctrl.sv
// Frame controller: owns the term counter and IDLE/ACCUM state, and flags the
// first and last accepted term of each frame.
module acc_frame_ctrl
  import acc_pkg::*;
#(
  parameter int N_TERMS = 9
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic clr,
  output logic first,
  output logic last,
  output logic busy
);

  localparam int CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;

  if (N_TERMS < 1) begin : g_bad_terms
    $error("acc_frame_ctrl: N_TERMS must be >= 1");
  end

  acc_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             accept;

  assign accept = in_valid && !clr;
  assign first  = accept && (cnt_q == '0);
  assign last   = accept && (cnt_q == CNT_W'(N_TERMS - 1));
  assign busy   = (state_q == ACCUM);
  assign cnt_d  = last ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else if (clr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else if (accept) begin
      cnt_q   <= cnt_d;
      state_q <= last ? IDLE : ACCUM;
    end
  end

endmodule

// File: rtl/acc_frame.sv
// Bias-plus-sum frame accumulator: one registered result per N_TERMS accepted terms.
// Define ACC_FRAME_SAT_EN to clamp on overflow instead of wrapping.
module acc_frame
  import acc_pkg::*;
#(
  parameter int IN_W    = IN_W_D,
  parameter int BIAS_W  = BIAS_W_D,
  parameter int ACC_W   = ACC_W_D,
  parameter int N_TERMS = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [IN_W-1:0]   din,
  input  logic signed [BIAS_W-1:0] bias,
  input  logic                     in_valid,
  input  logic                     clr,
  output logic signed [ACC_W-1:0]  dout,
  output logic                     out_valid,
  output logic                     ovf,
  output logic                     busy
);

  if (ACC_W <= IN_W || ACC_W <= BIAS_W || ACC_W > 63) begin : g_bad_width
    $error("acc_frame: need max(IN_W, BIAS_W) < ACC_W <= 63");
  end

  logic             first, last;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_acc_q, ovf_acc_d;
  logic [ACC_W-1:0] dout_q;
  logic             ovf_q, out_valid_q;
  logic [63:0]      din_x, bias_x, acc_x;
  add_res_t         res;
  logic             unused_hi;

  acc_frame_ctrl #(.N_TERMS(N_TERMS)) u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .clr      (clr),
    .first    (first),
    .last     (last),
    .busy     (busy)
  );

  assign din_x     = sext_acc(64'(din), 6'(IN_W - 1));
  assign bias_x    = sext_acc(64'(bias), 6'(BIAS_W - 1));
  assign acc_x     = sext_acc(64'(acc_q), 6'(ACC_W - 1));
  assign unused_hi = ^res.sum[63:ACC_W];

  always_comb begin
    res       = add_ovf(first ? bias_x : acc_x, din_x, 6'(ACC_W - 1));
    acc_d     = res.sum[ACC_W-1:0];
    ovf_acc_d = first ? res.ovf : (ovf_acc_q | res.ovf);
`ifdef ACC_FRAME_SAT_EN
    // Overflow implies equal operand signs, so din's sign gives the direction.
    if (res.ovf) acc_d = din_x[63] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q       <= '0;
      ovf_acc_q   <= 1'b0;
      dout_q      <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (clr) begin
        acc_q     <= '0;
        ovf_acc_q <= 1'b0;
      end else if (in_valid) begin
        acc_q     <= acc_d;
        ovf_acc_q <= ovf_acc_d;
        if (last) begin
          dout_q      <= acc_d;
          ovf_q       <= ovf_acc_d;
          out_valid_q <= 1'b1;
        end
      end
    end
  end

  assign dout      = dout_q;
  assign ovf       = ovf_q;
  assign out_valid = out_valid_q;

endmodule

// File: doc/acc_frame.md
Name: acc_frame

Overview:
Parametrised bias-plus-sum accumulator for the MAC datapath. Each frame is N_TERMS signed products arriving with a valid qualifier. The block seeds the first term with a sign-extended bias, sums the remaining terms and emits one registered result per frame. It replaces the fixed-width accumulator and controller pair, adding in_valid gating, frame abort, overflow reporting and optional saturation.

Parameters:
IN_W, 20, signed product (din) width
BIAS_W, 8, signed bias width
ACC_W, 22, accumulator/result width; elaboration error unless ACC_W > max(IN_W, BIAS_W)
N_TERMS, 9, terms per frame, >= 1; elaboration error if 0

Ports:
clk  input  1  clock, all logic rising-edge
rst  input  1  synchronous, active-low reset
din  input  IN_W  signed term
bias  input  BIAS_W  signed bias, sampled only on a frame's first accepted term
in_valid  input  1  din valid this cycle
clr  input  1  synchronous frame abort
dout  output  ACC_W  signed frame result, registered
out_valid  output  1  one-cycle pulse, dout is new
ovf  output  1  overflow occurred in the frame just output; valid with out_valid
busy  output  1  frame in progress (term count != 0)

Behaviour:
- Reset (rst==0 at clk edge): acc=0, cnt=0, dout=0, out_valid=0, ovf=0, busy=0. Any partial frame is discarded.
- Accepted term = in_valid==1 and clr==0. Cycles with in_valid==0 hold all state; gaps inside a frame are allowed.
- First term (cnt==0): acc <= sext(bias) + sext(din); ovf_acc <= overflow of that add.
- Later terms: acc <= acc + sext(din); ovf_acc <= ovf_acc | step overflow.
- cnt increments per accepted term.
- Last term (cnt==N_TERMS-1):
  - dout <= next acc value; ovf <= next ovf_acc; out_valid <= 1 on the following cycle; cnt <= 0.
- Latency: dout/out_valid register one cycle after the last term's edge.
- Back-to-back frames need no bubble: the cycle after a last term may be the next frame's first term.
- out_valid is high for exactly one cycle per completed frame. dout and ovf hold until the next completion.
- N_TERMS==1: every accepted term is both first and last, so dout = bias + din.
- clr==1: cnt <= 0, acc <= 0, ovf_acc <= 0; no out_valid. clr takes priority over a simultaneous in_valid, and that term is dropped. dout and ovf are not modified.
- Overflow is signed overflow of the ACC_W-bit add, i.e. operand signs equal and result sign differs.
- Default arithmetic: two's-complement wrap modulo 2^ACC_W.
- Control FSM states: IDLE (cnt==0), ACCUM (0 < cnt < N_TERMS). busy = (state==ACCUM).
  - IDLE -> ACCUM on an accepted term when N_TERMS > 1.
  - ACCUM -> IDLE on the last term or on clr.

Optional Feature:
ACC_FRAME_SAT_EN
- Defined: on a step overflow, acc clamps to +2^(ACC_W-1)-1 (positive overflow) or -2^(ACC_W-1) (negative overflow). Accumulation continues from the clamped value, and ovf is still flagged.
- Undefined: wrap arithmetic as above. Ports are identical in both builds.

Decomposition:
- Package acc_pkg:
  - default width constants IN_W_D=20, BIAS_W_D=8, ACC_W_D=22
  - FSM state enum acc_state_t {IDLE, ACCUM}
  - function sext_acc(): sign-extend to ACC_W
  - function add_ovf(): returns sum and overflow bit
- Sub-module acc_frame_ctrl:
  - owns cnt and the FSM
  - outputs first, last, busy from in_valid, clr and rst
  - datapath stays in acc_frame

Test Plan:
- Basic frame (N_TERMS=4): bias=8'hFD (-3), din=10,20,30,40 on consecutive cycles -> out_valid one cycle after the 4th term, dout=97, ovf=0, busy=0 afterwards.
- Gapped and back-to-back frames (N_TERMS=4): frame A with in_valid gaps, bias=0, din=1,2,3,4 -> dout=10. Frame B immediately after, bias=5, din=-1 x4 -> dout=1. Two out_valid pulses, B's exactly 4 cycles after A's.
- Overflow (N_TERMS=4): bias=127, din=20'h7FFFF x4.
  - Wrap build: dout=-2097029, ovf=1.
  - ACC_FRAME_SAT_EN build: dout=22'h1FFFFF (2097151), ovf=1.
  - A following frame with small values -> ovf=0.
- Abort: 2 terms accepted, then clr with in_valid=1 -> no out_valid, busy=0, dout unchanged. The next full frame (bias=2, din=1 x4) gives dout=6.
- Reset mid-frame: rst=0 after 3 of 4 terms -> all outputs 0 the next cycle. A fresh frame then completes correctly with no carry-over.
- N_TERMS=1: bias=-128, din=100 -> dout=-28, out_valid every accepted cycle.
